// File: rtl/mesm6_mem_arbiter.sv
// Shares one single-ported memory between the MESM-6 instruction and data buses.
// One transaction at a time, round-robin on conflict, ack timeout.
module mesm6_mem_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 48,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ibus_fetch,
  input  logic [ADDR_W-1:0] ibus_addr,
  output logic [DATA_W-1:0] ibus_input,
  output logic              ibus_done,
  input  logic              dbus_read,
  input  logic              dbus_write,
  input  logic [ADDR_W-1:0] dbus_addr,
  input  logic [DATA_W-1:0] dbus_output,
  output logic [DATA_W-1:0] dbus_input,
  output logic              dbus_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CNT_MAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  logic [1:0]       state;
  logic             grant_d;     // 1 = current transaction belongs to dbus
  logic             last_grant;  // winner of the most recent conflict, 1 = dbus
  logic             mask_i;
  logic             mask_d;
  logic [CNT_W-1:0] cnt;

  logic req_i;
  logic req_d;
  logic pick_d;
  logic timed_out;

  always_comb begin
    req_i     = ibus_fetch & ~mask_i;
    req_d     = (dbus_read | dbus_write) & ~mask_d;
    pick_d    = req_d & (~req_i | ~last_grant);
    timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);
  end

  assign mem_req   = (state == S_ACCESS);
  assign ibus_done = (state == S_RESP) & ~grant_d;
  assign dbus_done = (state == S_RESP) & grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      grant_d    <= 1'b0;
      last_grant <= 1'b0;
      mask_i     <= 1'b0;
      mask_d     <= 1'b0;
      cnt        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ibus_input <= '0;
      dbus_input <= '0;
      bus_error  <= 1'b0;
    end else begin
      mask_i <= 1'b0;
      mask_d <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_i | req_d) begin
            state   <= S_ACCESS;
            grant_d <= pick_d;
            cnt     <= '0;
            // Rotation only advances on a real conflict; a lone requester never shifts priority.
            if (req_i & req_d)
              last_grant <= pick_d;
            if (pick_d) begin
              mem_addr  <= dbus_addr;
              mem_we    <= dbus_write;
              mem_wdata <= dbus_output;
              if (dbus_read & dbus_write)
                bus_error <= 1'b1;
            end else begin
              mem_addr <= ibus_addr;
              mem_we   <= 1'b0;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            state <= S_RESP;
            if (!mem_we) begin
              if (grant_d) dbus_input <= mem_rdata;
              else         ibus_input <= mem_rdata;
            end
          end else if (timed_out) begin
            state     <= S_RESP;
            bus_error <= 1'b1;
            if (!mem_we) begin
              if (grant_d) dbus_input <= '0;
              else         ibus_input <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          // The core's request level lingers one cycle past done; hide it from the next IDLE.
          state  <= S_IDLE;
          mask_i <= ~grant_d;
          mask_d <= grant_d;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mesm6_mem_arbiter.md
# mesm6_mem_arbiter

Shares one single-ported 48-bit main-memory interface between the MESM-6 core's instruction bus (fetch) and data bus (read/write). The block sits between `mesm6_core` and the memory controller. It sequences one memory transaction at a time, arbitrates round-robin when both buses request together, returns registered read data with a one-cycle `done` pulse per bus, and aborts hung transactions with a timeout.

## Interface
- `ADDR_W`, default 15: word address width.
- `DATA_W`, default 48: memory word width.
- `TIMEOUT`, default 255: cycles to wait for `mem_ack` before aborting; 0 disables the timeout.

Ports (name, direction, width, meaning):
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ibus_fetch` in 1: instruction fetch request, level, held until done.
- `ibus_addr` in ADDR_W: fetch address.
- `ibus_input` out DATA_W: fetched word.
- `ibus_done` out 1: one-cycle completion pulse for the fetch.
- `dbus_read` in 1: data read request, level.
- `dbus_write` in 1: data write request, level.
- `dbus_addr` in ADDR_W: data address.
- `dbus_output` in DATA_W: write data from the core.
- `dbus_input` out DATA_W: read data to the core.
- `dbus_done` out 1: one-cycle completion pulse for the data access.
- `mem_req` out 1: memory request, held until ack.
- `mem_we` out 1: 1 = write.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid in the `mem_ack` cycle.
- `mem_ack` in 1: one-cycle acknowledge.
- `bus_error` out 1: sticky flag, set on timeout or on simultaneous `dbus_read` and `dbus_write`.

## Operation
- States:
  - IDLE: no transaction.
  - ACCESS: `mem_req` high.
  - RESP: done pulse cycle.
- Masking rule: in IDLE, a bus's request is masked for exactly one cycle after that bus's RESP. The core's request level persists one cycle past done because of the registered micro-op.
- IDLE to ACCESS when any unmasked request is pending. `mem_addr`, `mem_we` and `mem_wdata` are latched from the granted bus at that edge and stay stable throughout ACCESS.
- Arbitration on conflict: the grant goes to the bus not served last. `last_grant` resets to ibus, so the first conflict after reset goes to dbus. A single requester is always granted.
- `dbus_read` and `dbus_write` high together: performed as a write, and `bus_error` is set.
- ACCESS to RESP on `mem_ack`:
  - Read: `mem_rdata` is registered into `ibus_input` or `dbus_input` of the granted bus.
  - Write: the data output is unchanged.
- Timeout:
  - With `TIMEOUT` > 0, the ACCESS cycle counter reaching `TIMEOUT` without ack forces RESP.
  - The read output becomes 0 and `bus_error` is set.
  - A late `mem_ack` arriving in RESP or IDLE is ignored.
- RESP to IDLE unconditionally. The done pulse of the served bus is high only in RESP.
- A request dropped during ACCESS does not cancel the transaction; it completes and the done pulse still fires.
- `ibus_input` and `dbus_input` hold their values until the next read completion on the same bus.
- `bus_error` clears only on reset.

## Timing
- Reset values:
  - State IDLE.
  - `mem_req`, `mem_we`, `ibus_done`, `dbus_done` and `bus_error` are 0.
  - `mem_addr`, `mem_wdata`, `ibus_input` and `dbus_input` are 0.
  - Timeout counter 0; `last_grant` = ibus.
- Reset is honoured in any state. `mem_req` is 0 in the cycle after reset is sampled, and no done pulse is issued for the aborted transaction.
- Request sampled in IDLE at cycle N gives `mem_req` high from N+1.
- Ack in cycle M gives the done pulse and valid data at cycle M+1, and IDLE at M+2.
- Minimum latency: request at cycle 0 with ack at cycle 1 gives done at cycle 2.
- Back-to-back:
  - The other bus can be granted in the IDLE cycle at M+2, so its `mem_req` rises at M+3.
  - The same bus is masked at M+2, so its next `mem_req` rises at M+4 at the earliest.
- Timeout: with no ack, RESP is entered exactly `TIMEOUT` cycles after `mem_req` rises.

## Test plan
- Single fetch: `ibus_fetch`=1 with addr 0x0123 at cycle 0, memory acks at cycle 1 with 0xABCDEF012345. Required: `mem_req` high in cycle 1, `ibus_done` high in cycle 2 only, `ibus_input`=0xABCDEF012345, `dbus_done` stays 0.
- Conflict: fetch 0x0010 and read 0x0020 raised together after reset, acks after 1 cycle each. Required: dbus served first, then ibus, and each request's done pulses once. Repeat the conflict: ibus is served first.
- Write: `dbus_write`=1, addr 0x7FFF, data 0x000000000001. Required: `mem_we`=1 and `mem_wdata`=1 stable until ack, `dbus_done` pulses, `dbus_input` unchanged.
- Held request after done: the core keeps `ibus_fetch` high one cycle past `ibus_done`. Required: exactly one memory transaction.
- Timeout: `TIMEOUT`=4, read with no ack. Required: `dbus_done` 4 cycles after `mem_req` rises, `dbus_input`=0, `bus_error`=1. A late `mem_ack` is ignored.
- Reset mid-ACCESS: reset asserted while `mem_req`=1. Required: `mem_req`=0 the next cycle, no done pulse, all outputs at reset values.
